instr_mem_loader: RTL and testbench

Boot-time writer for the single-cycle core's instruction memory. It accepts a byte stream over a valid/ready handshake, packs the bytes into little-endian 32-bit words, and writes them to consecutive word-aligned addresses through a write port added to instruction memory. It holds the core in reset until the program image is fully loaded, then releases it.

---
 rtl/loader_pkg.sv | 16 +
 rtl/byte_packer.sv | 47 ++++
 rtl/instr_mem_loader.sv | 172 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction memory boot loader: FSM encoding
// and stream packing constants.
package loader_pkg;

  localparam int LOADER_BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    CNT_LO = 3'd0,
    CNT_HI = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: collects three bytes, then presents the
// full 32-bit word together with the fourth byte as it arrives.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_IDX = 2'(LOADER_BYTES_PER_WORD - 1);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] buf_q, buf_d;

  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (byte_en) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    buf_d[7:0]   = byte_in;
        2'd1:    buf_d[15:8]  = byte_in;
        2'd2:    buf_d[23:16] = byte_in;
        default: buf_d        = buf_q;
      endcase
    end
  end

  // The top byte bypasses the buffer so the word is ready on the 4th handshake.
  assign word_valid = byte_en && (cnt_q == LAST_IDX);
  assign word       = {byte_in, buf_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      buf_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader streaming a length-prefixed byte image into instruction memory and
// holding the core in reset until done. Define LOADER_CHECKSUM_EN for the XOR trailer.
//
// state  | meaning
// CNT_LO | waiting for low byte of word count
// CNT_HI | waiting for high byte of word count
// DATA   | receiving image bytes, one write per 4 bytes
// CHK    | waiting for checksum byte
// DONE   | image loaded, core released
// ERR    | load rejected, core held in reset
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        core_rst
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  loader_state_e state_q, state_d;
  logic [7:0]    cnt_lo_q, cnt_lo_d;
  logic [15:0]   n_q, n_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic          we_q, we_d;
  logic [31:0]   wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    chk_q, chk_d;
`endif

  logic          accept;
  logic          byte_en;
  logic          word_valid;
  logic [31:0]   word;
  logic [15:0]   n_in;
  loader_state_e end_state;

  always_comb begin
    case (state_q)
      CNT_LO, CNT_HI, DATA, CHK: s_ready = rst;
      default:                   s_ready = 1'b0;
    endcase
  end

  assign accept  = s_valid && s_ready;
  assign byte_en = accept && (state_q == DATA);
  assign n_in    = {s_data, cnt_lo_q};

`ifdef LOADER_CHECKSUM_EN
  assign end_state = CHK;
`else
  assign end_state = DONE;
`endif

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst),
    .byte_en    (byte_en),
    .byte_in    (s_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_lo_d   = cnt_lo_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    we_d       = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    busy_d     = busy_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d      = chk_q;
    if (byte_en) chk_d = chk_q ^ s_data;
`endif

    case (state_q)
      CNT_LO: begin
        if (accept) begin
          cnt_lo_d = s_data;
          busy_d   = 1'b1;
          state_d  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (accept) begin
          n_d = n_in;
          if ({1'b0, n_in} > DEPTH_L) state_d = ERR;
          else if (n_in == 16'd0)     state_d = end_state;
          else                        state_d = DATA;
        end
      end
      DATA: begin
        if (word_valid) begin
          we_d       = 1'b1;
          wa_d       = {14'd0, word_cnt_q, 2'b00};
          wd_d       = word;
          word_cnt_d = word_cnt_q + 16'd1;
          if (word_cnt_d == n_q) state_d = end_state;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) state_d = (s_data == chk_q) ? DONE : ERR;
      end
`endif
      default: state_d = state_q;
    endcase

    if (state_d == DONE || state_d == ERR) busy_d = 1'b0;
    // done lags DONE entry by a cycle so the final write lands before the core wakes.
    done_d = done_q | (state_q == DONE);
    err_d  = err_q | (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CNT_LO;
      cnt_lo_q   <= 8'd0;
      n_q        <= 16'd0;
      word_cnt_q <= 16'd0;
      we_q       <= 1'b0;
      wa_q       <= 32'd0;
      wd_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_lo_q   <= cnt_lo_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign we       = we_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign core_rst = done_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader; checksum cases run when LOADER_CHECKSUM_EN is defined.
module tb_instr_mem_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic        err;
  logic        core_rst;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] log_wa[$];
  logic [31:0] log_wd[$];

  instr_mem_loader #(.DEPTH(1024)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .core_rst (core_rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (we === 1'b1) begin
      log_wa.push_back(wa);
      log_wd.push_back(wd);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_we"},       32'(we),       32'd0);
    check({pfx, "_wa"},       wa,            32'd0);
    check({pfx, "_wd"},       wd,            32'd0);
    check({pfx, "_busy"},     32'(busy),     32'd0);
    check({pfx, "_done"},     32'(done),     32'd0);
    check({pfx, "_err"},      32'(err),      32'd0);
    check({pfx, "_core_rst"}, 32'(core_rst), 32'd0);
    check({pfx, "_s_ready"},  32'(s_ready),  32'd0);
  endtask

  // Presents a byte and returns #1 after the edge on which it was accepted.
  task automatic send(input logic [7:0] b);
    int guard = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("ready_timeout", 32'(guard >= 20), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_stall(input logic [7:0] b);
    send(b);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string pfx);
    s_valid = 1'b0;
    rst     = 1'b0;
    #1;
    check_reset_vals(pfx);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    log_wa.delete();
    log_wd.delete();
  endtask

  initial begin
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    #2;
    check_reset_vals("por");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", 32'(s_ready), 32'd1);
    check("idle_busy",  32'(busy),    32'd0);

    // Basic back-to-back load, N=2
    send(8'h02);
    check("basic_busy", 32'(busy), 32'd1);
    send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    check("basic_we0", 32'(we), 32'd1);
    check("basic_wa0", wa, 32'd0);
    check("basic_wd0", wd, 32'h00000013);
    send(8'h93); send(8'h00); send(8'h10);
    check("basic_we_gap", 32'(we), 32'd0);
    send(8'h00);
    s_valid = 1'b0;
    check("basic_we1",   32'(we),   32'd1);
    check("basic_wa1",   wa,        32'd4);
    check("basic_wd1",   wd,        32'h00100093);
    check("basic_done_early", 32'(done), 32'd0);
    check("basic_corerst_early", 32'(core_rst), 32'd0);
    @(posedge clk);
    #1;
    check("basic_done",     32'(done),     32'd1);
    check("basic_core_rst", 32'(core_rst), 32'd1);
    check("basic_busy_end", 32'(busy),     32'd0);
    check("basic_ready_end", 32'(s_ready), 32'd0);
    check("basic_nwrites",  32'(log_wa.size()), 32'd2);
    if (log_wa.size() == 2) begin
      check("basic_log_wa1", log_wa[1], 32'd4);
      check("basic_log_wd0", log_wd[0], 32'h00000013);
    end

    // Stalled source: same image with valid toggling
    do_reset("rst1");
    send_stall(8'h02); send_stall(8'h00);
    send_stall(8'h13); send_stall(8'h00); send_stall(8'h00); send_stall(8'h00);
    send_stall(8'h93); send_stall(8'h00); send_stall(8'h10); send_stall(8'h00);
    check("stall_done",    32'(done), 32'd1);
    check("stall_nwrites", 32'(log_wa.size()), 32'd2);
    if (log_wa.size() == 2) begin
      check("stall_wa0", log_wa[0], 32'd0);
      check("stall_wd0", log_wd[0], 32'h00000013);
      check("stall_wa1", log_wa[1], 32'd4);
      check("stall_wd1", log_wd[1], 32'h00100093);
    end

    // Oversize count N=1025
    do_reset("rst2");
    send(8'h01);
    send(8'h04);
    check("over_err",      32'(err),      32'd1);
    check("over_ready",    32'(s_ready),  32'd0);
    check("over_core_rst", 32'(core_rst), 32'd0);
    check("over_busy",     32'(busy),     32'd0);
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("over_err_sticky", 32'(err), 32'd1);
    check("over_done",       32'(done), 32'd0);
    check("over_nwrites",    32'(log_wa.size()), 32'd0);

    // Boundary count N=1024 is accepted
    do_reset("rst3");
    send(8'h00);
    send(8'h04);
    s_valid = 1'b0;
    check("max_err",  32'(err),  32'd0);
    check("max_busy", 32'(busy), 32'd1);

    // Empty image
    do_reset("rst4");
    send(8'h00);
    send(8'h00);
`ifdef LOADER_CHECKSUM_EN
    check("empty_done_chk_wait", 32'(done), 32'd0);
    send(8'h00);
`endif
    s_valid = 1'b0;
    check("empty_done_early", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check("empty_done",     32'(done),     32'd1);
    check("empty_core_rst", 32'(core_rst), 32'd1);
    check("empty_nwrites",  32'(log_wa.size()), 32'd0);

    // Reset mid-load, then a fresh N=1 image
    do_reset("rst5");
    send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    do_reset("mid");
    send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
`ifdef LOADER_CHECKSUM_EN
    send(8'h22);
`endif
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    check("reload_done",    32'(done), 32'd1);
    check("reload_nwrites", 32'(log_wa.size()), 32'd1);
    if (log_wa.size() == 1) begin
      check("reload_wa", log_wa[0], 32'd0);
      check("reload_wd", log_wd[0], 32'hDEADBEEF);
    end

`ifdef LOADER_CHECKSUM_EN
    // 33^E2^62^00 = B3
    do_reset("rst6");
    send(8'h01); send(8'h00);
    send(8'h33); send(8'hE2); send(8'h62); send(8'h00);
    send(8'hB3);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    check("chk_good_done", 32'(done), 32'd1);
    check("chk_good_err",  32'(err),  32'd0);
    check("chk_good_nwr",  32'(log_wa.size()), 32'd1);
    if (log_wd.size() == 1) check("chk_good_wd", log_wd[0], 32'h0062E233);

    do_reset("rst7");
    send(8'h01); send(8'h00);
    send(8'h33); send(8'hE2); send(8'h62); send(8'h00);
    send(8'hB0);
    s_valid = 1'b0;
    check("chk_bad_err", 32'(err), 32'd1);
    @(posedge clk);
    #1;
    check("chk_bad_done",     32'(done),     32'd0);
    check("chk_bad_core_rst", 32'(core_rst), 32'd0);
    check("chk_bad_nwr",      32'(log_wa.size()), 32'd1);
    if (log_wd.size() == 1) check("chk_bad_wd", log_wd[0], 32'h0062E233);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
